// File: rtl/dac_demap_ser_if.sv
// -----------------------------------------------------------------------------
// dac_demap_ser_if
//   Bundles the two valid/ready streams of dac_demap_ser.
//   Input stream  : DATA_I (128-bit byte-planar DAC word), VALID_I, READY_O
//   Output stream : A_O, B_O (16-bit samples), IDX_O (sample index k),
//                   LAST_O (final pair of the word), VALID_O, READY_I
//   master : the side that sources DATA_I and sinks the sample pairs
//   slave  : the dac_demap_ser block itself
// -----------------------------------------------------------------------------
interface dac_demap_ser_if;
   logic [127:0] DATA_I;
   logic         VALID_I;
   logic         READY_O;
   logic [15:0]  A_O;
   logic [15:0]  B_O;
   logic [1:0]   IDX_O;
   logic         LAST_O;
   logic         VALID_O;
   logic         READY_I;

   modport master (
      output DATA_I, VALID_I, READY_I,
      input  READY_O, A_O, B_O, IDX_O, LAST_O, VALID_O
   );

   modport slave (
      input  DATA_I, VALID_I, READY_I,
      output READY_O, A_O, B_O, IDX_O, LAST_O, VALID_O
   );
endinterface

// File: rtl/dac_demap_ser.sv
// -----------------------------------------------------------------------------
// dac_demap_ser
//   Inverse of the DAC byte-planar packer. Takes one 128-bit word holding four
//   samples each of channels A and B, rebuilds the 16-bit samples and emits
//   them as one A/B pair per cycle, four beats per word.
//
//   Word layout:
//     [127:96] = {A0h,A1h,A2h,A3h}   [95:64] = {A0l,A1l,A2l,A3l}
//     [63:32]  = {B0h,B1h,B2h,B3h}   [31:0]  = {B0l,B1l,B2l,B3l}
//
// Parameters
//   MSB_INV   : 1 inverts bit 15 of every restored sample
//   REV_ORDER : 1 emits sample 3 first and sample 0 last
//
// Ports
//   CLK_I      : clock
//   RSTN_I     : asynchronous active-low reset
//   bus        : dac_demap_ser_if.slave (input word stream + output pair stream)
//   WORD_CNT_O : number of fully emitted words, wraps at 2^32
// -----------------------------------------------------------------------------
module dac_demap_ser #(
   parameter bit MSB_INV   = 1'b0,
   parameter bit REV_ORDER = 1'b0
) (
   input  logic                  CLK_I,
   input  logic                  RSTN_I,
   dac_demap_ser_if.slave        bus,
   output logic [31:0]           WORD_CNT_O
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]   state;
   logic         armed;      // low until the first edge after reset release
   logic [127:0] word_q;     // word currently being serialised
   logic [1:0]   beat_q;     // emission position n = 0..3
   logic [31:0]  word_cnt;

   logic [15:0]  a_q;
   logic [15:0]  b_q;
   logic [1:0]   idx_q;
   logic         last_q;
   logic         valid_q;

   logic         take;
   logic         last_take;
   logic         ready;
   logic         accept;
   logic [1:0]   next_beat;
   logic [1:0]   first_idx;
   logic [1:0]   next_idx;
   logic [31:0]  first_pair;
   logic [31:0]  next_pair;

   // Emission position -> sample index within the source word.
   function automatic logic [1:0] beat_to_idx(input logic [1:0] n);
      return REV_ORDER ? (2'd3 - n) : n;
   endfunction

   // Rebuild sample pair k from the byte-planar word; result is {A_k, B_k}.
   // The optional MSB flip sits here so both channels get the same treatment
   // before the value reaches the output register.
   function automatic logic [31:0] pick_pair(input logic [127:0] w,
                                             input logic [1:0]   k);
      logic [15:0] a;
      logic [15:0] b;
      a = '0;
      b = '0;
      for (int i = 0; i < 4; i++) begin
         if (k == 2'(i)) begin
            a = {w[127 - 8*i -: 8], w[95 - 8*i -: 8]};
            b = {w[63  - 8*i -: 8], w[31 - 8*i -: 8]};
         end
      end
      if (MSB_INV) begin
         a[15] = ~a[15];
         b[15] = ~b[15];
      end
      return {a, b};
   endfunction

   // NOTE: every signal driven here gets a value on every path (all plain
   // assigns), so no latch can be inferred.
   always_comb begin
      take       = valid_q & bus.READY_I;
      last_take  = take & last_q;
      // A new word is taken while idle, or on the same edge the final pair of
      // the current word leaves, which keeps full-rate streams bubble free.
      ready      = armed & ((state == ST_IDLE) | last_take);
      accept     = bus.VALID_I & ready;
      next_beat  = beat_q + 2'd1;
      first_idx  = beat_to_idx(2'd0);
      next_idx   = beat_to_idx(next_beat);
      first_pair = pick_pair(bus.DATA_I, first_idx);
      next_pair  = pick_pair(word_q, next_idx);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         state    <= ST_IDLE;
         armed    <= 1'b0;
         // NOTE: the holding register is reset as well, so no stale word
         // from before a reset can ever be replayed.
         word_q   <= '0;
         beat_q   <= '0;
         word_cnt <= '0;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         armed <= 1'b1;

         if (last_take) begin
            word_cnt <= word_cnt + 32'd1;
         end

         if (accept) begin
            // First pair comes straight from DATA_I so it is visible one
            // cycle after the accepting edge.
            word_q     <= bus.DATA_I;
            state      <= ST_SEND;
            beat_q     <= 2'd0;
            {a_q, b_q} <= first_pair;
            idx_q      <= first_idx;
            last_q     <= 1'b0;
            valid_q    <= 1'b1;
         end else if (take) begin
            if (last_q) begin
               state   <= ST_IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end else begin
               beat_q     <= next_beat;
               {a_q, b_q} <= next_pair;
               idx_q      <= next_idx;
               last_q     <= (next_beat == 2'd3);
            end
         end
         // Stalled (valid but not ready): everything holds.
      end
   end

   assign bus.READY_O = ready;
   assign bus.A_O     = a_q;
   assign bus.B_O     = b_q;
   assign bus.IDX_O   = idx_q;
   assign bus.LAST_O  = last_q;
   assign bus.VALID_O = valid_q;
   assign WORD_CNT_O  = word_cnt;

endmodule

// File: tb/tb_dac_demap_ser.sv
// -----------------------------------------------------------------------------
// tb_dac_demap_ser
//   Self-checking bench for dac_demap_ser. Two instances: u_dut with default
//   parameters and u_dut_p with MSB_INV=1, REV_ORDER=1. The reference model
//   turns each accepted word into a queue of expected pairs using shift
//   arithmetic on the byte-planar layout.
// -----------------------------------------------------------------------------
module tb_dac_demap_ser;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  idx;
      logic        last;
   } pair_t;

   localparam logic [127:0] W_MAP = 128'h12569ADE_3478BCF0_00224466_11335577;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dac_demap_ser_if bus0 ();
   dac_demap_ser_if bus1 ();
   logic [31:0] cnt0;
   logic [31:0] cnt1;

   dac_demap_ser u_dut (
      .CLK_I      (clk),
      .RSTN_I     (rst_n),
      .bus        (bus0),
      .WORD_CNT_O (cnt0)
   );

   dac_demap_ser #(.MSB_INV(1'b1), .REV_ORDER(1'b1)) u_dut_p (
      .CLK_I      (clk),
      .RSTN_I     (rst_n),
      .bus        (bus1),
      .WORD_CNT_O (cnt1)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cnt_exp = '0;
   logic [127:0] src_q[$];
   pair_t        exp_q[$];

   // Pair emitted at position k of word w, from the layout equations.
   function automatic pair_t model_pair(input logic [127:0] w, input int k,
                                        input bit inv, input bit rev);
      pair_t p;
      int    s;
      s      = rev ? 3 - k : k;
      p.a    = {8'(w >> (120 - 8*s)), 8'(w >> (88 - 8*s))};
      p.b    = {8'(w >> (56 - 8*s)),  8'(w >> (24 - 8*s))};
      if (inv) begin
         p.a = p.a ^ 16'h8000;
         p.b = p.b ^ 16'h8000;
      end
      p.idx  = 2'(s);
      p.last = (k == 3);
      return p;
   endfunction

   function automatic pair_t obs0();
      pair_t p;
      p.a = bus0.A_O; p.b = bus0.B_O; p.idx = bus0.IDX_O; p.last = bus0.LAST_O;
      return p;
   endfunction

   function automatic logic [127:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Random valid/ready stream on bus0 against the pair-queue model.
   task automatic run_stream(input string name, input int vpct, input int rpct,
                             input int max_cyc);
      int          cyc = 0;
      bit          vld = 1'b0;
      bit          exp_valid;
      bit          exp_ready;
      logic [127:0] cur = '0;
      pair_t       front;
      while ((src_q.size() != 0 || vld || exp_q.size() != 0) && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         exp_valid = (exp_q.size() != 0);
         checks++;
         if (bus0.VALID_O !== exp_valid) begin
            errors++;
            $display("FAIL %s valid cyc=%0d: got %b want %b", name, cyc, bus0.VALID_O, exp_valid);
         end
         if (exp_valid) begin
            front = exp_q[0];
            checks++;
            if (obs0() !== front) begin
               errors++;
               $display("FAIL %s pair cyc=%0d: got %h want %h", name, cyc, obs0(), front);
            end
         end
         if (!vld && src_q.size() != 0 && $urandom_range(99) < vpct) begin
            vld = 1'b1;
            cur = src_q.pop_front();
         end
         bus0.VALID_I = vld;
         bus0.DATA_I  = cur;
         bus0.READY_I = ($urandom_range(99) < rpct);
         #1;
         exp_ready = !exp_valid || (bus0.READY_I && exp_q.size() == 1);
         checks++;
         if (bus0.READY_O !== exp_ready) begin
            errors++;
            $display("FAIL %s ready cyc=%0d: got %b want %b", name, cyc, bus0.READY_O, exp_ready);
         end
         if (exp_valid && bus0.READY_I) begin
            front = exp_q.pop_front();
            if (front.last) cnt_exp = cnt_exp + 32'd1;
         end
         if (vld && exp_ready) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(model_pair(cur, k, 1'b0, 1'b0));
            vld = 1'b0;
         end
      end
      checks++;
      if (cyc >= max_cyc) begin
         errors++;
         $display("FAIL %s timeout: got %0d cycles want < %0d", name, cyc, max_cyc);
      end
      bus0.VALID_I = 1'b0;
      bus0.READY_I = 1'b1;
      @(negedge clk);
      checks++;
      if (bus0.VALID_O !== 1'b0) begin
         errors++;
         $display("FAIL %s drain valid: got %b want 0", name, bus0.VALID_O);
      end
      checks++;
      if (cnt0 !== cnt_exp) begin
         errors++;
         $display("FAIL %s word_cnt: got %h want %h", name, cnt0, cnt_exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.VALID_I = 1'b1; bus0.DATA_I = W_MAP; bus0.READY_I = 1'b1;
      bus1.VALID_I = 1'b1; bus1.DATA_I = W_MAP; bus1.READY_I = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus0.VALID_O, bus0.LAST_O, bus0.A_O, bus0.B_O, bus0.IDX_O} !== 36'h0) begin
         errors++;
         $display("FAIL reset outputs: got %b%b %h %h %h want all 0",
                  bus0.VALID_O, bus0.LAST_O, bus0.A_O, bus0.B_O, bus0.IDX_O);
      end
      checks++;
      if (cnt0 !== 32'h0) begin
         errors++;
         $display("FAIL reset word_cnt: got %h want 0", cnt0);
      end
      checks++;
      if (bus0.READY_O !== 1'b0) begin
         errors++;
         $display("FAIL reset ready: got %b want 0", bus0.READY_O);
      end
      bus0.VALID_I = 1'b0;
      bus1.VALID_I = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus0.READY_O !== 1'b0) begin
         errors++;
         $display("FAIL release ready before edge: got %b want 0", bus0.READY_O);
      end
      @(negedge clk);
      checks++;
      if (bus0.READY_O !== 1'b1) begin
         errors++;
         $display("FAIL release ready after edge: got %b want 1", bus0.READY_O);
      end
      cnt_exp = '0;
   endtask

   task automatic test_map();
      logic [15:0] ea[4];
      logic [15:0] eb[4];
      ea[0] = 16'h1234; ea[1] = 16'h5678; ea[2] = 16'h9ABC; ea[3] = 16'hDEF0;
      eb[0] = 16'h0011; eb[1] = 16'h2233; eb[2] = 16'h4455; eb[3] = 16'h6677;
      @(negedge clk);
      bus0.VALID_I = 1'b1; bus0.DATA_I = W_MAP; bus0.READY_I = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus0.VALID_I = 1'b0;
         checks++;
         if ({bus0.VALID_O, bus0.A_O, bus0.B_O, bus0.IDX_O, bus0.LAST_O} !==
             {1'b1, ea[k], eb[k], 2'(k), (k == 3)}) begin
            errors++;
            $display("FAIL map pair %0d: got v=%b a=%h b=%h i=%0d l=%b want a=%h b=%h i=%0d",
                     k, bus0.VALID_O, bus0.A_O, bus0.B_O, bus0.IDX_O, bus0.LAST_O, ea[k], eb[k], k);
         end
      end
      @(negedge clk);
      cnt_exp = cnt_exp + 32'd1;
      checks++;
      if (bus0.VALID_O !== 1'b0 || cnt0 !== 32'd1) begin
         errors++;
         $display("FAIL map end: got valid=%b cnt=%h want valid=0 cnt=1", bus0.VALID_O, cnt0);
      end
   endtask

   task automatic test_back_to_back();
      src_q.push_back(rand_word());
      src_q.push_back(rand_word());
      run_stream("back_to_back", 100, 100, 40);
   endtask

   task automatic test_backpressure();
      logic [127:0] w2;
      pair_t        p;
      w2 = rand_word();
      @(negedge clk);
      bus0.VALID_I = 1'b1; bus0.DATA_I = W_MAP; bus0.READY_I = 1'b1;
      @(negedge clk);
      bus0.VALID_I = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus0.READY_I = 1'b0;
      bus0.VALID_I = 1'b1; bus0.DATA_I = w2;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({bus0.VALID_O, bus0.A_O, bus0.B_O, bus0.IDX_O, bus0.LAST_O} !==
             {1'b1, 16'h9ABC, 16'h4455, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL stall hold %0d: got v=%b a=%h b=%h i=%0d l=%b want 9abc 4455 2",
                     i, bus0.VALID_O, bus0.A_O, bus0.B_O, bus0.IDX_O, bus0.LAST_O);
         end
         checks++;
         if (bus0.READY_O !== 1'b0) begin
            errors++;
            $display("FAIL stall ready %0d: got %b want 0", i, bus0.READY_O);
         end
         @(negedge clk);
      end
      bus0.READY_I = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({bus0.A_O, bus0.LAST_O, bus0.READY_O} !== {16'hDEF0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL resume last: got a=%h l=%b r=%b want def0 1 1",
                  bus0.A_O, bus0.LAST_O, bus0.READY_O);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus0.VALID_I = 1'b0;
         p = model_pair(w2, k, 1'b0, 1'b0);
         checks++;
         if (bus0.VALID_O !== 1'b1 || obs0() !== p) begin
            errors++;
            $display("FAIL held word pair %0d: got v=%b %h want %h", k, bus0.VALID_O, obs0(), p);
         end
      end
      @(negedge clk);
      cnt_exp = cnt_exp + 32'd2;
      checks++;
      if (bus0.VALID_O !== 1'b0 || cnt0 !== cnt_exp) begin
         errors++;
         $display("FAIL backpressure end: got valid=%b cnt=%h want 0 %h", bus0.VALID_O, cnt0, cnt_exp);
      end
   endtask

   task automatic test_params();
      logic [15:0] ea[4];
      logic [15:0] eb[4];
      ea[0] = 16'h5EF0; ea[1] = 16'h1ABC; ea[2] = 16'hD678; ea[3] = 16'h9234;
      eb[0] = 16'hE677; eb[1] = 16'hC455; eb[2] = 16'hA233; eb[3] = 16'h8011;
      @(negedge clk);
      bus1.VALID_I = 1'b1; bus1.DATA_I = W_MAP; bus1.READY_I = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus1.VALID_I = 1'b0;
         checks++;
         if ({bus1.VALID_O, bus1.A_O, bus1.B_O, bus1.IDX_O, bus1.LAST_O} !==
             {1'b1, ea[k], eb[k], 2'(3 - k), (k == 3)}) begin
            errors++;
            $display("FAIL params pair %0d: got v=%b a=%h b=%h i=%0d l=%b want a=%h b=%h i=%0d",
                     k, bus1.VALID_O, bus1.A_O, bus1.B_O, bus1.IDX_O, bus1.LAST_O, ea[k], eb[k], 3 - k);
         end
      end
      @(negedge clk);
      checks++;
      if (bus1.VALID_O !== 1'b0 || cnt1 !== 32'd1) begin
         errors++;
         $display("FAIL params end: got valid=%b cnt=%h want 0 1", bus1.VALID_O, cnt1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) src_q.push_back(rand_word());
      run_stream("random", 40, 60, 2000);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus0.VALID_I = 1'b1; bus0.DATA_I = W_MAP; bus0.READY_I = 1'b1;
      @(negedge clk);
      bus0.VALID_I = 1'b0;
      @(negedge clk);
      checks++;
      if (bus0.A_O !== 16'h5678 || bus0.VALID_O !== 1'b1) begin
         errors++;
         $display("FAIL mid pair1: got a=%h v=%b want 5678 1", bus0.A_O, bus0.VALID_O);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.VALID_O, bus0.LAST_O, bus0.A_O, bus0.B_O, bus0.READY_O} !== 35'h0 || cnt0 !== 32'h0) begin
         errors++;
         $display("FAIL mid reset: got v=%b l=%b a=%h b=%h r=%b cnt=%h want all 0",
                  bus0.VALID_O, bus0.LAST_O, bus0.A_O, bus0.B_O, bus0.READY_O, cnt0);
      end
      cnt_exp = '0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      src_q.push_back(W_MAP);
      run_stream("after_reset", 100, 100, 20);
   endtask

   task automatic test_wrap();
      @(negedge clk);
      u_dut.word_cnt = 32'hFFFF_FFFF;
      cnt_exp = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (cnt0 !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap preload: got %h want ffffffff", cnt0);
      end
      src_q.push_back(rand_word());
      run_stream("wrap", 100, 70, 40);
      checks++;
      if (cnt0 !== 32'h0) begin
         errors++;
         $display("FAIL wrap value: got %h want 0", cnt0);
      end
   endtask

   initial begin
      bus0.VALID_I = 1'b0; bus0.DATA_I = '0; bus0.READY_I = 1'b1;
      bus1.VALID_I = 1'b0; bus1.DATA_I = '0; bus1.READY_I = 1'b1;
      test_reset();
      test_map();
      test_back_to_back();
      test_backpressure();
      test_params();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
